trap_seq: RTL and testbench
===========================

# trap_seq

Parametrised trap sequencer for the CPU control path. It generalises the single hardware-interrupt, software-interrupt and exception sequences into one prioritised, vectored engine with NUM_IRQ maskable lines that can each be configured as edge- or level-sensitive. The CU raises exception and software-interrupt requests and grants traps at instruction-fetch boundaries. During each trap the block drives the register, memory and mode control strobes that push the return state and load the PC with the vector.

## Interface
- NUM_IRQ, 8, number of hardware interrupt lines; legal range 1..30
- IRQ_EDGE, 0 (NUM_IRQ bits), per-line mode; bit set = rising-edge, clear = level
- VEC_BASE, 32'h10, word address of the vector for cause 0
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- irq  in  NUM_IRQ  hardware interrupt lines, synchronous to clk
- irq_en  in  NUM_IRQ  per-line enable
- imask  in  1  global interrupt enable (status.imask)
- except_req  in  1  CU exception request (privilege violation or bad opcode), one-cycle pulse
- swint_req  in  1  CU software interrupt (INT) request, one-cycle pulse
- take  in  1  CU grant at fetch boundary; ignored unless req=1 and state is IDLE
- req  out  1  a trap is pending and grantable
- busy  out  1  sequence in progress (any state other than IDLE)
- done  out  1  one-cycle pulse in the last sequence cycle
- cause  out  CAUSE_W = $clog2(NUM_IRQ+2)  latched cause: 0 = exception, 1 = swint, 2+i = irq[i]
- vec  out  32  VEC_BASE + cause, zero-extended
- oe_vec  out  1  drive vec onto the ALU A bus
- mem_wr, pre_dec_sp, oe_alu, ld_reg, ld_imask, imask_in, ld_mode  out  1 each  datapath strobes
- alu_op  out  alu_op_e  ALU operation
- sel_a_reg, sel_b_reg, sel_in_reg  out  reg_e  register selects
- mode_in  out  cpu_mode_e  mode value

## Operation
- Pending sources:
  - except_p and sw_p are set by their request pulses and cleared when that cause is taken.
  - Edge line i: pend[i] sets when irq[i]=1 and the previous-cycle sample is 0. It clears when taken. If a new edge arrives in the same cycle as the clear, set wins.
  - Level line i: pending = irq[i]; never latched.
- Eligibility:
  - Exception and swint ignore imask.
  - Line i is eligible when pending & irq_en[i] & imask.
- Priority: exception > swint > irq[0] > … > irq[NUM_IRQ-1]. req = any eligible source.
- In IDLE, take & req latches the winning cause, clears its pending bit, and moves to PUSH_PC. Sources that arrive later wait for the next take.
- States and transitions: IDLE → PUSH_PC → [PUSH_ST] → LOAD_VEC → IDLE.
- PUSH_PC: pre_dec_sp=1, sel_a_reg=PC, sel_b_reg=SP, mem_wr=1.
- PUSH_ST (only with the macro): the same strobes, with sel_a_reg=STATUS.
- LOAD_VEC:
  - oe_vec=1, alu_op=PASSA, oe_alu=1, sel_in_reg=PC, ld_reg=1.
  - mode_in=SUPERVISOR, ld_mode=1, done=1.
  - For cause≠0 also ld_imask=1, imask_in=0. An exception leaves imask unchanged.
- Outside the states listed above, every strobe is 0, alu_op is 0 and every select is 0.
- req is held at 0 while busy=1.

## Timing
- Reset: state IDLE, pend/except_p/sw_p/edge samples all 0, cause 0, every output 0 (vec = VEC_BASE).
- Reset asserted mid-sequence aborts immediately. No strobe is asserted after rst rises.
- Request pulse at cycle t → req=1 at t+1 (registered pending).
- Edge on irq at cycle t → req=1 at t+1, provided the line is enabled and imask=1.
- take at cycle t → PUSH_PC at t+1, LOAD_VEC at t+2, IDLE at t+3.
- With the macro, each state after take shifts one cycle later.
- cause and vec are stable from t+1 until the next take.
- A level irq still high after LOAD_VEC: req is normally masked because imask was cleared. If imask=1 on return to IDLE, req reasserts in that same cycle.
- except_req and swint_req arriving during busy are latched, not lost.

## Configuration
- TRAP_PUSH_STATUS_EN defined: the PUSH_ST state is present, the return frame is {STATUS, PC}, and trap latency is 3 cycles.
- TRAP_PUSH_STATUS_EN undefined: PUSH_ST and its logic are absent, only PC is pushed, and trap latency is 2 cycles.

## Test plan
- Exception and software interrupt:
  - except_req pulse, then take → cause=0, vec=0x10, PUSH_PC then LOAD_VEC, ld_imask=0, ld_mode=1, done at t+2.
  - Repeat with swint_req → cause=1, vec=0x11, ld_imask=1 with imask_in=0.
- Same-cycle priority: except_req, swint_req and irq[3] in one cycle with imask=1 and irq_en=all → three successive takes give cause 0, then 1, then 5 (vec 0x15).
- Masking: irq[2] level high with irq_en[2]=0 → req=0. Set irq_en[2]=1 with imask=0 → req=0. Set imask=1 → req=1 next cycle.
- Edge mode (IRQ_EDGE=8'h01):
  - A 1-cycle irq[0] pulse with no take → pending is held, and the later take gives cause=2.
  - A second edge in the cycle the take clears pending → req=1 again after the sequence.
- Reset and build variant:
  - rst asserted in PUSH_PC → all outputs 0 and busy=0 in the same cycle, pending cleared.
  - With TRAP_PUSH_STATUS_EN: sel_a_reg=STATUS at t+2 and done at t+3.

Source files
------------

// File: rtl/trap_seq.sv
// Prioritised, vectored trap sequencer: exception > swint > irq[0..N-1], pushes return state and loads PC.
// Optional TRAP_PUSH_STATUS_EN adds a PUSH_ST state so the return frame becomes {STATUS, PC}.
package trap_seq_pkg;
  typedef enum logic [2:0] {ALU_NOP = 3'd0, ALU_PASSA = 3'd1, ALU_ADD = 3'd2, ALU_SUB = 3'd3} alu_op_e;
  typedef enum logic [2:0] {REG_NONE = 3'd0, REG_PC = 3'd1, REG_SP = 3'd2, REG_STATUS = 3'd3} reg_e;
  typedef enum logic {MODE_USER = 1'b0, MODE_SUPERVISOR = 1'b1} cpu_mode_e;
endpackage

module trap_seq
  import trap_seq_pkg::*;
#(
  parameter int                 NUM_IRQ  = 8,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
  parameter logic [31:0]        VEC_BASE = 32'h10,
  localparam int                CAUSE_W  = $clog2(NUM_IRQ + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               imask,
  input  logic               except_req,
  input  logic               swint_req,
  input  logic               take,
  output logic               req,
  output logic               busy,
  output logic               done,
  output logic [CAUSE_W-1:0] cause,
  output logic [31:0]        vec,
  output logic               oe_vec,
  output logic               mem_wr,
  output logic               pre_dec_sp,
  output logic               oe_alu,
  output logic               ld_reg,
  output logic               ld_imask,
  output logic               imask_in,
  output logic               ld_mode,
  output alu_op_e            alu_op,
  output reg_e               sel_a_reg,
  output reg_e               sel_b_reg,
  output reg_e               sel_in_reg,
  output cpu_mode_e          mode_in
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PUSH_PC  = 2'd1,
    S_LOAD_VEC = 2'd2
`ifdef TRAP_PUSH_STATUS_EN
    , S_PUSH_ST = 2'd3
`endif
  } state_e;

  state_e               state, state_nxt;
  logic                 except_p, sw_p;
  logic [NUM_IRQ-1:0]   line_pend, elig;
  logic                 any_pend, take_go;
  logic [CAUSE_W-1:0]   win_cause, cause_q;

  // Edge lines latch until taken (a fresh edge beats the clear); level lines follow irq directly.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    if (IRQ_EDGE[gi]) begin : g_edge
      logic prev, pend, clr;
      assign clr = take_go & ~except_p & ~sw_p & (win_cause == CAUSE_W'(gi + 2));
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev <= 1'b0;
          pend <= 1'b0;
        end else begin
          prev <= irq[gi];
          pend <= (irq[gi] & ~prev) | (pend & ~clr);
        end
      end
      assign line_pend[gi] = pend;
    end else begin : g_level
      assign line_pend[gi] = irq[gi];
    end
  end

  assign elig = line_pend & irq_en & {NUM_IRQ{imask}};

  always_comb begin
    any_pend  = except_p | sw_p | (|elig);
    win_cause = '0;
    if (except_p) begin
      win_cause = '0;
    end else if (sw_p) begin
      win_cause = CAUSE_W'(1);
    end else begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (elig[i]) win_cause = CAUSE_W'(i + 2);
      end
    end
  end

  assign take_go = (state == S_IDLE) & take & any_pend;
  assign req     = (state == S_IDLE) & any_pend;
  assign busy    = (state != S_IDLE);
  assign cause   = cause_q;
  assign vec     = VEC_BASE + {{(32 - CAUSE_W){1'b0}}, cause_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      except_p <= 1'b0;
      sw_p     <= 1'b0;
      cause_q  <= '0;
    end else begin
      except_p <= except_req | (except_p & ~take_go);
      sw_p     <= swint_req | (sw_p & ~(take_go & ~except_p));
      if (take_go) cause_q <= win_cause;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (take_go) state_nxt = S_PUSH_PC;
`ifdef TRAP_PUSH_STATUS_EN
      S_PUSH_PC:  state_nxt = S_PUSH_ST;
      S_PUSH_ST:  state_nxt = S_LOAD_VEC;
`else
      S_PUSH_PC:  state_nxt = S_LOAD_VEC;
`endif
      S_LOAD_VEC: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done       = 1'b0;
    oe_vec     = 1'b0;
    mem_wr     = 1'b0;
    pre_dec_sp = 1'b0;
    oe_alu     = 1'b0;
    ld_reg     = 1'b0;
    ld_imask   = 1'b0;
    imask_in   = 1'b0;
    ld_mode    = 1'b0;
    alu_op     = ALU_NOP;
    sel_a_reg  = REG_NONE;
    sel_b_reg  = REG_NONE;
    sel_in_reg = REG_NONE;
    mode_in    = MODE_USER;
    case (state)
      S_PUSH_PC: begin
        pre_dec_sp = 1'b1;
        mem_wr     = 1'b1;
        sel_a_reg  = REG_PC;
        sel_b_reg  = REG_SP;
      end
`ifdef TRAP_PUSH_STATUS_EN
      S_PUSH_ST: begin
        pre_dec_sp = 1'b1;
        mem_wr     = 1'b1;
        sel_a_reg  = REG_STATUS;
        sel_b_reg  = REG_SP;
      end
`endif
      S_LOAD_VEC: begin
        oe_vec     = 1'b1;
        alu_op     = ALU_PASSA;
        oe_alu     = 1'b1;
        sel_in_reg = REG_PC;
        ld_reg     = 1'b1;
        mode_in    = MODE_SUPERVISOR;
        ld_mode    = 1'b1;
        done       = 1'b1;
        // Exceptions keep the current interrupt mask.
        ld_imask   = (cause_q != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: directed scenarios plus a randomized run against a behavioural model.
module tb_trap_seq;
  import trap_seq_pkg::*;

`ifdef TRAP_PUSH_STATUS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  // {busy, req, done, mem_wr, pre_dec_sp, oe_alu, ld_reg, ld_imask, imask_in, ld_mode, oe_vec}
  localparam logic [10:0] ST_REQ      = 11'h200;
  localparam logic [10:0] ST_PUSH     = 11'h4C0;
  localparam logic [10:0] ST_LOAD_EXC = 11'h533;
  localparam logic [10:0] ST_LOAD_INT = 11'h53B;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] irq = '0, irq_en = '0;
  logic       imask = 1'b0, except_req = 1'b0, swint_req = 1'b0, take = 1'b0;
  logic       req, busy, done, oe_vec, mem_wr, pre_dec_sp, oe_alu, ld_reg, ld_imask, imask_in, ld_mode;
  logic [3:0] cause;
  logic [31:0] vec;
  alu_op_e    alu_op;
  reg_e       sel_a_reg, sel_b_reg, sel_in_reg;
  cpu_mode_e  mode_in;
  int checks = 0, errors = 0;

  trap_seq #(.NUM_IRQ(8), .IRQ_EDGE(8'h01), .VEC_BASE(32'h10)) dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_en(irq_en), .imask(imask),
    .except_req(except_req), .swint_req(swint_req), .take(take),
    .req(req), .busy(busy), .done(done), .cause(cause), .vec(vec), .oe_vec(oe_vec),
    .mem_wr(mem_wr), .pre_dec_sp(pre_dec_sp), .oe_alu(oe_alu), .ld_reg(ld_reg),
    .ld_imask(ld_imask), .imask_in(imask_in), .ld_mode(ld_mode), .alu_op(alu_op),
    .sel_a_reg(sel_a_reg), .sel_b_reg(sel_b_reg), .sel_in_reg(sel_in_reg), .mode_in(mode_in)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs_strb();
    return {busy, req, done, mem_wr, pre_dec_sp, oe_alu, ld_reg, ld_imask, imask_in, ld_mode, oe_vec};
  endfunction

  function automatic logic [12:0] obs_sel();
    return {alu_op, sel_a_reg, sel_b_reg, sel_in_reg, mode_in};
  endfunction

  // Expected strobes for sequence position ph (0 = idle, LAT = vector load).
  function automatic logic [10:0] exp_strb(input int ph, input int c);
    if (ph == 0) return 11'h000;
    if (ph == LAT) return (c == 0) ? ST_LOAD_EXC : ST_LOAD_INT;
    return ST_PUSH;
  endfunction

  function automatic logic [12:0] exp_sel(input int ph);
    if (ph == 0) return {ALU_NOP, REG_NONE, REG_NONE, REG_NONE, MODE_USER};
    if (ph == LAT) return {ALU_PASSA, REG_NONE, REG_NONE, REG_PC, MODE_SUPERVISOR};
    return {ALU_NOP, (ph == 1) ? REG_PC : REG_STATUS, REG_SP, REG_NONE, MODE_USER};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (obs_strb() !== 11'h000) begin errors++; $display("FAIL reset_strobes: got %h want 000", obs_strb()); end
    checks++; if (obs_sel() !== 13'h0) begin errors++; $display("FAIL reset_selects: got %h want 0", obs_sel()); end
    checks++; if (cause !== 4'd0 || vec !== 32'h10) begin errors++; $display("FAIL reset_vec: got cause %0d vec %h want 0/10", cause, vec); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exc_swint();
    for (int c = 0; c < 2; c++) begin
      except_req = (c == 0);
      swint_req  = (c == 1);
      tick();
      except_req = 1'b0;
      swint_req  = 1'b0;
      take = 1'b1;
      @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL req_after_pulse c%0d: got %b want 1", c, req); end
      tick();
      take = 1'b0;
      for (int ph = 1; ph <= LAT; ph++) begin
        @(negedge clk);
        checks++; if (obs_strb() !== exp_strb(ph, c)) begin errors++; $display("FAIL seq_strobes c%0d ph%0d: got %h want %h", c, ph, obs_strb(), exp_strb(ph, c)); end
        checks++; if (obs_sel() !== exp_sel(ph)) begin errors++; $display("FAIL seq_selects c%0d ph%0d: got %h want %h", c, ph, obs_sel(), exp_sel(ph)); end
        checks++; if (cause !== 4'(c) || vec !== 32'(16 + c)) begin errors++; $display("FAIL seq_cause c%0d: got cause %0d vec %h", c, cause, vec); end
        tick();
      end
      @(negedge clk);
      checks++; if (obs_strb() !== 11'h000) begin errors++; $display("FAIL seq_return c%0d: got %h want 000", c, obs_strb()); end
      tick();
    end
  endtask

  task automatic test_priority();
    int exp_c[3] = '{0, 1, 5};
    imask = 1'b1; irq_en = 8'hFF; irq = 8'h08;
    except_req = 1'b1; swint_req = 1'b1;
    tick();
    except_req = 1'b0; swint_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      take = 1'b1;
      @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL prio_req k%0d: got %b want 1", k, req); end
      tick();
      take = 1'b0;
      @(negedge clk);
      checks++; if (cause !== 4'(exp_c[k]) || vec !== 32'(16 + exp_c[k])) begin errors++; $display("FAIL prio_cause k%0d: got %0d vec %h want %0d", k, cause, vec, exp_c[k]); end
      repeat (LAT) tick();
    end
    irq = 8'h00;
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL prio_drain: got %b want 0", req); end
    tick();
  endtask

  task automatic test_masking();
    irq = 8'h04; irq_en = 8'h00; imask = 1'b1;
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mask_en: got %b want 0", req); end
    tick();
    irq_en = 8'h04; imask = 1'b0;
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mask_imask: got %b want 0", req); end
    tick();
    imask = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL mask_open: got %b want 1", req); end
    tick();
    irq = 8'h00;
    tick();
  endtask

  task automatic test_edge();
    irq_en = 8'hFF; imask = 1'b1; irq = 8'h00;
    tick();
    irq = 8'h01;
    tick();
    irq = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL edge_hold k%0d: got %b want 1", k, req); end
      tick();
    end
    take = 1'b1;
    tick();
    take = 1'b0;
    @(negedge clk);
    checks++; if (cause !== 4'd2 || vec !== 32'h12) begin errors++; $display("FAIL edge_cause: got %0d vec %h want 2/12", cause, vec); end
    repeat (LAT) tick();
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL edge_cleared: got %b want 0", req); end
    irq = 8'h01;
    tick();
    irq = 8'h00;
    tick();
    take = 1'b1; irq = 8'h01;
    tick();
    take = 1'b0; irq = 8'h00;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || cause !== 4'd2) begin errors++; $display("FAIL edge_retake: got busy %b cause %0d want 1/2", busy, cause); end
    repeat (LAT) tick();
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL edge_set_wins: got %b want 1", req); end
    take = 1'b1;
    tick();
    take = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic test_reset_mid();
    irq = 8'h00;
    except_req = 1'b1; swint_req = 1'b1;
    tick();
    except_req = 1'b0; swint_req = 1'b0; take = 1'b1;
    tick();
    take = 1'b0;
    @(negedge clk);
    checks++; if (obs_strb() !== ST_PUSH) begin errors++; $display("FAIL rst_mid_push: got %h want %h", obs_strb(), ST_PUSH); end
    #1 rst = 1'b1;
    #1;
    checks++; if (obs_strb() !== 11'h000 || obs_sel() !== 13'h0) begin errors++; $display("FAIL rst_mid_abort: got %h/%h want 0", obs_strb(), obs_sel()); end
    checks++; if (vec !== 32'h10) begin errors++; $display("FAIL rst_mid_vec: got %h want 10", vec); end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got %b want 0", req); end
    tick();
  endtask

  task automatic test_random();
    bit m_exc, m_sw, m_e0, m_prev0, go, p;
    int ph, m_cause, win;
    logic [10:0] es;
    irq = 8'h00; except_req = 1'b0; swint_req = 1'b0; take = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_exc = 0; m_sw = 0; m_e0 = 0; m_prev0 = 0; ph = 0; m_cause = 0;
    for (int n = 0; n < 400; n++) begin
      except_req = ($urandom_range(0, 7) == 0);
      swint_req  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      if ($urandom_range(0, 7) == 0) irq_en = 8'($urandom);
      imask = ($urandom_range(0, 3) != 0);
      take  = 1'($urandom_range(0, 1));
      win = -1;
      if (m_exc) win = 0;
      else if (m_sw) win = 1;
      else if (imask) begin
        for (int i = 0; i < 8; i++) begin
          p = (i == 0) ? m_e0 : irq[i];
          if (win < 0 && p && irq_en[i]) win = i + 2;
        end
      end
      es = exp_strb(ph, m_cause) | ((ph == 0 && win >= 0) ? ST_REQ : 11'h000);
      @(negedge clk);
      checks++; if (obs_strb() !== es) begin errors++; $display("FAIL rand_strobes n%0d: got %h want %h", n, obs_strb(), es); end
      checks++; if (obs_sel() !== exp_sel(ph)) begin errors++; $display("FAIL rand_selects n%0d: got %h want %h", n, obs_sel(), exp_sel(ph)); end
      checks++; if (cause !== 4'(m_cause) || vec !== 32'(16 + m_cause)) begin errors++; $display("FAIL rand_cause n%0d: got %0d vec %h want %0d", n, cause, vec, m_cause); end
      go = (ph == 0) && take && (win >= 0);
      m_exc   = except_req || (m_exc && !(go && win == 0));
      m_sw    = swint_req || (m_sw && !(go && win == 1));
      m_e0    = (irq[0] && !m_prev0) || (m_e0 && !(go && win == 2));
      m_prev0 = irq[0];
      if (go) begin
        m_cause = win;
        ph = 1;
      end else if (ph == LAT) ph = 0;
      else if (ph != 0) ph++;
      tick();
    end
    except_req = 1'b0; swint_req = 1'b0; take = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exc_swint();
    test_priority();
    test_masking();
    test_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
